// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Elastic pipeline register placed between two CPU stages. It carries LANES
// fields of DATA_W bits each, with a valid/ready handshake on both sides.
//
// A two-entry skid buffer keeps in_ready registered, so no combinational
// path runs from out_ready to in_ready. Asserting flush kills the stage and
// inserts a bubble. The bubble can keep the PC lane so that an exception
// can still be reported. Two saturating counters record stall cycles and
// flush cycles.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; overrides flush and handshakes
//   in_valid   upstream presents a word on in_data
//   in_ready   stage can accept a word (registered)
//   in_data    lane k occupies bits [k*DATA_W +: DATA_W]
//   flush      discard stage contents and this cycle's input; load bubble
//   out_valid  out_data holds a live word
//   out_ready  downstream accepts the head word
//   out_data   head word (main register)
//   stall_cnt  cycles with out_valid=1 and out_ready=0, saturating
//   flush_cnt  cycles with flush=1, saturating
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W           = 32,
    parameter int LANES            = 6,
    parameter int PC_LANE          = 4,
    parameter bit KEEP_PC_ON_FLUSH = 1'b1,
    parameter int CNT_W            = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    localparam int WORD_W = LANES * DATA_W;

    // EMPTY: main invalid; FULL: main valid, skid invalid; SKID: both valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WORD_W-1:0]   main_q;
    logic [WORD_W-1:0]   main_next;
    logic [WORD_W-1:0]   skid_q;
    logic [WORD_W-1:0]   skid_next;
    logic                ready_q;
    logic                in_fire;
    logic                out_fire;
    logic                stall_evt;

    // Increment that sticks at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        else
            return v + CNT_W'(1);
    endfunction

    // Bubble word: all lanes zero, optionally keeping the incoming PC lane
    // so a trap handler still sees which instruction was killed.
    function automatic logic [WORD_W-1:0] make_bubble(input logic [WORD_W-1:0] d);
        logic [WORD_W-1:0] b;
        b = '0;
        if (KEEP_PC_ON_FLUSH)
            b[PC_LANE*DATA_W +: DATA_W] = d[PC_LANE*DATA_W +: DATA_W];
        return b;
    endfunction

    // in_ready is a flop that mirrors (state != SKID). It is computed from
    // the next state, so it always agrees with the state register.
    assign in_ready  = ready_q;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;

    assign in_fire   = in_valid & ready_q;
    assign out_fire  = out_valid & out_ready;
    // Uses the pre-flush out_valid, so a stalled cycle that is also flushed
    // still counts as a stall.
    assign stall_evt = out_valid & ~out_ready;

    // Next-state and datapath-load selection
    always_comb begin
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;

        if (flush) begin
            // The incoming word is dropped even if it handshook this
            // cycle. The skid word is abandoned: EMPTY never reads it.
            state_next = EMPTY;
            main_next  = make_bubble(in_data);
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_next = FULL;
                        main_next  = in_data;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_next  = in_data;
                    end else if (in_fire) begin
                        // Downstream stalled while a word was accepted.
                        // Park the word in skid and drop in_ready next cycle.
                        state_next = SKID;
                        skid_next  = in_data;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                SKID: begin
                    // in_ready is low here, so only a drain can happen.
                    if (out_fire) begin
                        state_next = FULL;
                        main_next  = skid_q;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // State, storage and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            ready_q   <= 1'b1;
            main_q    <= '0;
            skid_q    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            ready_q   <= (state_next != SKID);
            main_q    <= main_next;
            skid_q    <= skid_next;
            if (stall_evt)
                stall_cnt <= sat_inc(stall_cnt);
            if (flush)
                flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. Three instances share the same stimulus:
//   u_dut    default parameters (KEEP_PC_ON_FLUSH=1, CNT_W=16)
//   u_nokeep KEEP_PC_ON_FLUSH=0, used to check the all-zero bubble
//   u_cnt4   CNT_W=4, used to check counter saturation
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int LN = 6;
    localparam int WW = DW * LN;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          flush;
    logic          out_ready;
    logic [WW-1:0] in_data;

    logic          in_ready,  out_valid;
    logic [WW-1:0] out_data;
    logic [15:0]   stall_cnt, flush_cnt;

    logic          nk_in_ready, nk_out_valid;
    logic [WW-1:0] nk_out_data;
    logic [15:0]   nk_stall_cnt, nk_flush_cnt;

    logic          c4_in_ready, c4_out_valid;
    logic [WW-1:0] c4_out_data;
    logic [3:0]    c4_stall_cnt, c4_flush_cnt;

    int total;
    int bad;

    pipe_stage_reg #(.DATA_W(DW), .LANES(LN), .PC_LANE(4), .KEEP_PC_ON_FLUSH(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .LANES(LN), .PC_LANE(4), .KEEP_PC_ON_FLUSH(1'b0), .CNT_W(16)) u_nokeep (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nk_in_ready),
        .in_data(in_data), .flush(flush), .out_valid(nk_out_valid),
        .out_ready(out_ready), .out_data(nk_out_data),
        .stall_cnt(nk_stall_cnt), .flush_cnt(nk_flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .LANES(LN), .PC_LANE(4), .KEEP_PC_ON_FLUSH(1'b1), .CNT_W(4)) u_cnt4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c4_in_ready),
        .in_data(in_data), .flush(flush), .out_valid(c4_out_valid),
        .out_ready(out_ready), .out_data(c4_out_data),
        .stall_cnt(c4_stall_cnt), .flush_cnt(c4_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word n: lanes 0..3 = {0xA0+k, n[23:0]}, PC lane = 0x3000+4n, Instr = n
    function automatic logic [WW-1:0] mkword(input int n);
        logic [WW-1:0] w;
        logic [31:0]   lane;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            lane = {8'(8'hA0 + k), 24'(n)};
            w[k*DW +: DW] = lane;
        end
        lane = 32'(32'h3000 + 4 * n);
        w[4*DW +: DW] = lane;
        lane = 32'(n);
        w[5*DW +: DW] = lane;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [WW-1:0] flush_word;
    logic [WW-1:0] bubble_exp;

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out_valid", WW'(out_valid), WW'(1'b0));
        chk("rst_in_ready",  WW'(in_ready),  WW'(1'b1));
        chk("rst_out_data",  out_data,       '0);
        chk("rst_stall_cnt", WW'(stall_cnt), '0);
        chk("rst_flush_cnt", WW'(flush_cnt), '0);

        // Streaming: one word per cycle, 1-cycle latency
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            in_data = mkword(n);
            tick();
            chk("stream_data",  out_data,       mkword(n));
            chk("stream_valid", WW'(out_valid), WW'(1'b1));
            chk("stream_ready", WW'(in_ready),  WW'(1'b1));
            chk("stream_stall", WW'(stall_cnt), '0);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", WW'(out_valid), WW'(1'b0));

        // Backpressure: A accepted, then 3 stalled cycles; B parks in skid
        in_valid  = 1'b1;
        in_data   = mkword(16);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_data   = mkword(17);
        tick();
        chk("bp_ready_low", WW'(in_ready), WW'(1'b0));
        chk("bp_head_a",    out_data,      mkword(16));
        in_data = mkword(18);
        tick();
        tick();
        chk("bp_c_held",   WW'(in_ready),  WW'(1'b0));
        chk("bp_head_a2",  out_data,       mkword(16));
        chk("bp_stall3",   WW'(stall_cnt), WW'(16'd3));
        out_ready = 1'b1;
        tick();
        chk("bp_head_b",   out_data,       mkword(17));
        chk("bp_ready_up", WW'(in_ready),  WW'(1'b1));
        tick();
        chk("bp_head_c",   out_data,       mkword(18));
        chk("bp_valid_c",  WW'(out_valid), WW'(1'b1));
        in_valid = 1'b0;
        tick();
        chk("bp_empty",    WW'(out_valid), WW'(1'b0));
        chk("bp_stall_end", WW'(stall_cnt), WW'(16'd3));

        // Flush from SKID; stall count goes 3 -> 4 -> 5 (flush cycle counts)
        in_valid  = 1'b1;
        in_data   = mkword(20);
        out_ready = 1'b0;
        tick();
        in_data = mkword(21);
        tick();
        chk("fl_in_skid", WW'(in_ready), WW'(1'b0));
        flush_word = '1;
        flush_word[4*DW +: DW] = 32'h0000_3010;
        bubble_exp = '0;
        bubble_exp[4*DW +: DW] = 32'h0000_3010;
        flush   = 1'b1;
        in_data = flush_word;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", WW'(out_valid),    WW'(1'b0));
        chk("fl_in_ready",  WW'(in_ready),     WW'(1'b1));
        chk("fl_bubble_pc", out_data,          bubble_exp);
        chk("fl_flush_cnt", WW'(flush_cnt),    WW'(16'd1));
        chk("fl_stall_cnt", WW'(stall_cnt),    WW'(16'd5));
        chk("fl_nokeep",    nk_out_data,       '0);
        chk("fl_nokeep_vld", WW'(nk_out_valid), WW'(1'b0));
        out_ready = 1'b1;
        tick();
        chk("fl_bubble_hold", out_data,        bubble_exp);

        // Reset mid-operation: rebuild SKID with stall_cnt=5, then reset
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = mkword(30);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_data   = mkword(31);
        for (int i = 0; i < 5; i++) tick();
        chk("rm_stall5",  WW'(stall_cnt), WW'(16'd5));
        chk("rm_in_skid", WW'(in_ready),  WW'(1'b0));
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        chk("rm_out_valid", WW'(out_valid), WW'(1'b0));
        chk("rm_in_ready",  WW'(in_ready),  WW'(1'b1));
        chk("rm_out_data",  out_data,       '0);
        chk("rm_stall_cnt", WW'(stall_cnt), '0);
        chk("rm_flush_cnt", WW'(flush_cnt), '0);
        in_data   = mkword(32);
        out_ready = 1'b1;
        tick();
        chk("rm_first_valid", WW'(out_valid), WW'(1'b1));
        chk("rm_first_data",  out_data,       mkword(32));
        in_valid = 1'b0;
        tick();

        // Counter saturation on the CNT_W=4 instance
        in_valid  = 1'b1;
        in_data   = mkword(40);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("sat_cnt4", WW'(c4_stall_cnt), WW'((i > 15) ? 15 : i));
        end
        chk("sat_cnt16", WW'(stall_cnt), WW'(16'd20));
        chk("sat_valid", WW'(out_valid), WW'(1'b1));
        chk("sat_data",  out_data,       mkword(40));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register between two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries LANES fields of DATA_W bits with a valid/ready handshake. A 2-entry skid buffer keeps in_ready registered. A flush inserts a bubble that can preserve the PC lane for exception reporting, and saturating counters record stall and flush events for performance analysis.

## Interface
- DATA_W, 32, width of one lane
- LANES, 6, number of lanes (e.g. V1, V2, EXT, PC8, PC, Instr)
- PC_LANE, 4, lane index holding the PC; must be < LANES
- KEEP_PC_ON_FLUSH, 1, 1: bubble keeps incoming PC lane; 0: bubble is all-zero
- CNT_W, 16, counter width
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream has a word
- in_ready  out  1  stage can accept; registered
- in_data  in  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W]
- flush  in  1  kill stage contents and this cycle's input; insert bubble
- out_valid  out  1  out_data holds a live word
- out_ready  in  1  downstream accepts
- out_data  out  LANES*DATA_W  head word
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- flush_cnt  out  CNT_W  cycles with flush=1, saturating

## Operation
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- Storage: a main register drives out_data, and a skid register holds one overflow word.
- State machine:
  - EMPTY (main invalid)
  - FULL (main valid, skid invalid)
  - SKID (both valid)
- in_ready = (state != SKID), taken from a register, with no combinational path from out_ready.
- Transitions when flush=0:
  - EMPTY: in_fire -> FULL, main<=in_data. Otherwise stay in EMPTY.
  - FULL: in_fire & out_fire -> FULL, main<=in_data.
  - FULL: in_fire & !out_fire -> SKID, skid<=in_data.
  - FULL: !in_fire & out_fire -> EMPTY.
  - FULL: otherwise hold.
  - SKID: out_fire -> FULL, main<=skid. Otherwise hold. in_fire is impossible in SKID.
- flush=1 has priority over all of the above:
  - Next state is EMPTY, with out_valid=0 and in_ready=1.
  - The incoming word is discarded, even if in_fire=1.
  - Main register loads the bubble: all lanes 0, except the PC lane, which gets in_data's PC lane when KEEP_PC_ON_FLUSH=1.
  - Skid contents are lost.
- In EMPTY, out_data holds its last loaded value (last word or bubble). Consumers must qualify it with out_valid.
- Counters:
  - stall_cnt increments when out_valid & !out_ready.
  - flush_cnt increments when flush=1.
  - Both stick at 2^CNT_W-1.
  - Counters keep counting during flush cycles; stall is evaluated on the pre-flush out_valid.

## Timing
- Reset values: state=EMPTY, out_valid=0, in_ready=1, out_data=0, skid=0, stall_cnt=0, flush_cnt=0.
- Reset overrides flush and all handshake activity.
- Reset mid-operation drops both words in the same edge.
- Latency: 1 cycle from in_fire to out_valid when EMPTY.
- Throughput: 1 word/cycle while out_ready=1.
- Backpressure:
  - The first out_ready=0 cycle with in_fire parks the new word in skid.
  - in_ready drops on the following cycle.
  - Words are never lost or duplicated, and order is preserved.
- Simultaneous out_fire and in_fire in FULL: the stage stays FULL, and out_data shows the new word next cycle.
- The bubble is visible on out_data the cycle after flush, with out_valid=0.

## Test plan
- Streaming:
  - Stimulus: reset, then in_valid=1 with out_ready=1; lanes carry PC=0x3000+4n and Instr=n for n=0..7.
  - Response: out_data equals input word n one cycle later, out_valid held 1, in_ready held 1, stall_cnt=0.
- Backpressure:
  - Stimulus: stream words A, B, C, with out_ready=0 for 3 cycles after A is accepted.
  - Response: in_ready falls one cycle after B is accepted and C is held upstream. When out_ready returns, the stage emits A, B, C in order. stall_cnt=3.
- Flush with KEEP_PC_ON_FLUSH=1:
  - Stimulus: stage in SKID, then flush=1 with in_data PC lane=0x3010 and other lanes 0xFFFFFFFF.
  - Response: next cycle out_valid=0, in_ready=1, PC lane=0x3010, all other lanes 0, flush_cnt=1.
- Flush with KEEP_PC_ON_FLUSH=0:
  - Stimulus: same as the previous scenario.
  - Response: out_data is all-zero.
- Reset mid-operation:
  - Stimulus: stage in SKID with stall_cnt=5, then reset=1 for one cycle.
  - Response: all outputs at reset values. The first word after reset appears with 1-cycle latency.
- Counter saturation:
  - Stimulus: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles.
  - Response: stall_cnt stops at 15 and stays there.
